// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared states, BCD limits and prescaler sizing helpers
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction
  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one up/down BCD digit with clear, clamped load and ripple carry
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       dir,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       clr,
  output logic [3:0] value,
  output logic       carry_out
);
  logic [3:0] r_val;
  assign value = r_val;
  assign carry_out = dir ? (r_val == BCD_MAX) : (r_val == 4'd0);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_val <= '0;
    else if (clr) r_val <= '0;
    else if (load) r_val <= clamp9(load_val);
    else if (en) r_val <= dir ? ((r_val == BCD_MAX) ? 4'd0 : r_val + 4'd1)
                              : ((r_val == 4'd0) ? BCD_MAX : r_val - 4'd1);
  end
endmodule

// File: rtl/stopwatch_timer_core.sv
// stopwatch_timer_core: prescaled run/pause/expire BCD stopwatch with preset load, lap freeze and terminal detect
module stopwatch_timer_core
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 100,
  parameter int NUM_DIGITS = 4,
  parameter int WRAP_UP    = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    up,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] preset,
  input  logic                    lap,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    running,
  output logic                    lap_hold,
  output logic                    expired,
  output logic                    tick
);
  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int PW  = cnt_width(DIV);
  localparam int W   = 4 * NUM_DIGITS;
  if (TICK_HZ < 1 || CLK_HZ % TICK_HZ != 0 || DIV < 2 || NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_param
    $error("stopwatch_timer_core: illegal parameter set");
  end
  state_t                r_state, w_next;
  logic [PW-1:0]         r_pre;
  logic                  r_dir, r_lap_d, r_hold, r_tick;
  logic [W-1:0]          r_disp, w_cnt;
  logic [NUM_DIGITS-1:0] w_carry, w_en;
  logic                  w_run, w_wrap_tick, w_term, w_step, w_clr, w_load, w_edit, w_lap_rise;
  assign w_run       = r_state == RUN;
  assign w_wrap_tick = w_run && r_pre == PW'(DIV - 1);
  // all carries set means all-9s going up or all-0s going down
  assign w_term      = r_dir ? (&w_carry && WRAP_UP == 0) : (&w_carry || w_cnt == W'(1));
  assign w_step      = w_wrap_tick && !(&w_carry && (!r_dir || WRAP_UP == 0));
  assign w_edit      = (clear || load) && !w_run;
  assign w_clr       = clear && !w_run;
  assign w_load      = load && !clear && !w_run;
  assign w_lap_rise  = lap && !r_lap_d;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    if (i == 0) begin : g_lsd
      assign w_en[i] = w_step;
    end else begin : g_hi
      assign w_en[i] = w_step && &w_carry[i-1:0];
    end
    bcd_digit u_digit (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (w_en[i]),
      .dir      (r_dir),
      .load     (w_load),
      .load_val (preset[4*i +: 4]),
      .clr      (w_clr),
      .value    (w_cnt[4*i +: 4]),
      .carry_out(w_carry[i])
    );
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (start && !stop) ? RUN : IDLE;
      RUN:     w_next = stop ? PAUSED : (w_wrap_tick && w_term) ? EXPIRED : RUN;
      PAUSED:  w_next = (start && !stop) ? RUN : PAUSED;
      EXPIRED: w_next = (clear || load) ? IDLE : EXPIRED;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre   <= '0;
      r_dir   <= 1'b1;
      r_lap_d <= 1'b0;
      r_hold  <= 1'b0;
      r_tick  <= 1'b0;
      r_disp  <= '0;
    end else begin
      r_lap_d <= lap;
      r_tick  <= w_wrap_tick;
      if (!w_run) r_dir <= up;
      if (w_edit || w_wrap_tick || (w_next == RUN && !w_run)) r_pre <= '0;
      else if (w_run) r_pre <= r_pre + 1'b1;
      if (w_edit) r_hold <= 1'b0;
      else if (w_lap_rise && (r_state == RUN || r_state == PAUSED)) begin
        r_hold <= !r_hold;
        if (!r_hold) r_disp <= w_cnt;
      end
    end
  end
  assign digits   = r_hold ? r_disp : w_cnt;
  assign running  = w_run;
  assign lap_hold = r_hold;
  assign expired  = r_state == EXPIRED;
  assign tick     = r_tick;
endmodule

// File: tb/tb_stopwatch_timer_core.sv
// tb_stopwatch_timer_core: vector table, async-reset sequence and random run against an integer model
module tb_stopwatch_timer_core;
  localparam int DIV = 10;
  localparam int MAXV = 99;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;
  typedef struct {
    logic [5:0]  ctl;
    logic [7:0]  preset;
    int          ncyc;
    logic [11:0] exp1;
    logic [11:0] exp0;
  } vec_t;
  logic clk = 0, reset_n = 1, start = 0, stop = 0, up = 1, clear = 0, load = 0, lap = 0;
  logic [7:0] preset = 0;
  logic [7:0] d1, d0;
  logic r1, h1, e1, t1, r0, h0, e0, t0;
  int total = 0, bad = 0;
  vec_t vt[$];
  int m_st[2], m_cnt[2], m_pre[2], m_disp[2];
  bit m_dir[2], m_hold[2], m_tick[2], m_lapd[2];
  always #5 clk = ~clk;
  stopwatch_timer_core #(.CLK_HZ(10), .TICK_HZ(1), .NUM_DIGITS(2), .WRAP_UP(1)) u_w1 (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .up(up), .clear(clear), .load(load),
    .preset(preset), .lap(lap), .digits(d1), .running(r1), .lap_hold(h1), .expired(e1), .tick(t1)
  );
  stopwatch_timer_core #(.CLK_HZ(10), .TICK_HZ(1), .NUM_DIGITS(2), .WRAP_UP(0)) u_w0 (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .up(up), .clear(clear), .load(load),
    .preset(preset), .lap(lap), .digits(d0), .running(r0), .lap_hold(h0), .expired(e0), .tick(t0)
  );
  function automatic logic [11:0] o(logic [7:0] d, logic r, logic h, logic e, logic t);
    return {d, r, h, e, t};
  endfunction
  function automatic void add(logic [5:0] c, logic [7:0] p, int n, logic [11:0] e);
    vt.push_back('{c, p, n, e, e});
  endfunction
  function automatic void add2(logic [5:0] c, logic [7:0] p, int n, logic [11:0] e, logic [11:0] e0);
    vt.push_back('{c, p, n, e, e0});
  endfunction
  function automatic logic [7:0] to_bcd(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction
  function automatic int preset_val(logic [7:0] p);
    int hi, lo;
    hi = (p[7:4] > 4'd9) ? 9 : int'(p[7:4]);
    lo = (p[3:0] > 4'd9) ? 9 : int'(p[3:0]);
    return hi * 10 + lo;
  endfunction
  function automatic logic [11:0] exp_of(int k);
    return {to_bcd(m_hold[k] ? m_disp[k] : m_cnt[k]), m_st[k] == M_RUN, m_hold[k], m_st[k] == M_EXP, m_tick[k]};
  endfunction
  task automatic chk(string name, logic [11:0] got, logic [11:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = M_IDLE; m_cnt[k] = 0; m_pre[k] = 0; m_disp[k] = 0;
      m_dir[k] = 1; m_hold[k] = 0; m_tick[k] = 0; m_lapd[k] = 0;
    end
  endtask
  task automatic model_step(int k, bit wrap);
    bit run, tk, term, edit;
    int nst, ncnt;
    run = m_st[k] == M_RUN;
    tk = run && m_pre[k] == DIV - 1;
    ncnt = m_cnt[k];
    term = 0;
    if (tk) begin
      if (m_dir[k]) begin
        if (m_cnt[k] == MAXV) begin
          if (wrap) ncnt = 0;
          else term = 1;
        end else ncnt = m_cnt[k] + 1;
      end else if (m_cnt[k] == 0) term = 1;
      else begin
        ncnt = m_cnt[k] - 1;
        term = ncnt == 0;
      end
    end
    edit = !run && (clear || load);
    if (!run && clear) ncnt = 0;
    else if (!run && load) ncnt = preset_val(preset);
    nst = m_st[k];
    case (m_st[k])
      M_IDLE, M_PAUSE: if (start && !stop) nst = M_RUN;
      M_RUN: if (stop) nst = M_PAUSE; else if (term) nst = M_EXP;
      M_EXP: if (clear || load) nst = M_IDLE;
      default: ;
    endcase
    if (edit || tk || (nst == M_RUN && !run)) m_pre[k] = 0;
    else if (run) m_pre[k]++;
    if (edit) m_hold[k] = 0;
    else if (lap && !m_lapd[k] && (m_st[k] == M_RUN || m_st[k] == M_PAUSE)) begin
      if (!m_hold[k]) m_disp[k] = m_cnt[k];
      m_hold[k] = !m_hold[k];
    end
    m_tick[k] = tk;
    if (!run) m_dir[k] = up;
    m_lapd[k] = lap;
    m_cnt[k] = ncnt;
    m_st[k] = nst;
  endtask
  initial begin
    int p;
    add(6'b101000, 8'h00, 1,   o(8'h00, 1, 0, 0, 0));
    add(6'b001000, 8'h00, 9,   o(8'h00, 1, 0, 0, 0));
    add(6'b001000, 8'h00, 1,   o(8'h01, 1, 0, 0, 1));
    add(6'b001000, 8'h00, 1,   o(8'h01, 1, 0, 0, 0));
    add(6'b001000, 8'h00, 239, o(8'h25, 1, 0, 0, 1));
    add(6'b011000, 8'h00, 1,   o(8'h25, 0, 0, 0, 0));
    add(6'b101000, 8'h00, 11,  o(8'h26, 1, 0, 0, 1));
    add(6'b011000, 8'h00, 1,   o(8'h26, 0, 0, 0, 0));
    add(6'b001010, 8'h12, 1,   o(8'h12, 0, 0, 0, 0));
    add(6'b101000, 8'h12, 1,   o(8'h12, 1, 0, 0, 0));
    add(6'b001001, 8'h12, 1,   o(8'h12, 1, 1, 0, 0));
    add(6'b001000, 8'h12, 49,  o(8'h12, 1, 1, 0, 1));
    add(6'b001001, 8'h12, 1,   o(8'h17, 1, 0, 0, 0));
    add(6'b011000, 8'h12, 1,   o(8'h17, 0, 0, 0, 0));
    add(6'b101000, 8'h12, 1,   o(8'h17, 1, 0, 0, 0));
    add(6'b001100, 8'h12, 1,   o(8'h17, 1, 0, 0, 0));
    add(6'b011000, 8'h12, 1,   o(8'h17, 0, 0, 0, 0));
    add(6'b001100, 8'h12, 1,   o(8'h00, 0, 0, 0, 0));
    add(6'b000010, 8'h03, 1,   o(8'h03, 0, 0, 0, 0));
    add(6'b100000, 8'h03, 1,   o(8'h03, 1, 0, 0, 0));
    add(6'b000000, 8'h03, 10,  o(8'h02, 1, 0, 0, 1));
    add(6'b000000, 8'h03, 10,  o(8'h01, 1, 0, 0, 1));
    add(6'b000000, 8'h03, 10,  o(8'h00, 0, 0, 1, 1));
    add(6'b100000, 8'h03, 1,   o(8'h00, 0, 0, 1, 0));
    add(6'b000000, 8'h03, 20,  o(8'h00, 0, 0, 1, 0));
    add(6'b000100, 8'h03, 1,   o(8'h00, 0, 0, 0, 0));
    add(6'b001010, 8'hA7, 1,   o(8'h97, 0, 0, 0, 0));
    add(6'b111000, 8'hA7, 1,   o(8'h97, 0, 0, 0, 0));
    add(6'b001000, 8'hA7, 5,   o(8'h97, 0, 0, 0, 0));
    add(6'b000100, 8'hA7, 1,   o(8'h00, 0, 0, 0, 0));
    add(6'b100000, 8'hA7, 1,   o(8'h00, 1, 0, 0, 0));
    add(6'b000000, 8'hA7, 10,  o(8'h00, 0, 0, 1, 1));
    add(6'b001010, 8'h98, 1,   o(8'h98, 0, 0, 0, 0));
    add(6'b101000, 8'h98, 1,   o(8'h98, 1, 0, 0, 0));
    add(6'b001000, 8'h98, 10,  o(8'h99, 1, 0, 0, 1));
    add2(6'b001000, 8'h98, 10, o(8'h00, 1, 0, 0, 1), o(8'h99, 0, 0, 1, 1));
    add2(6'b001000, 8'h98, 10, o(8'h01, 1, 0, 0, 1), o(8'h99, 0, 0, 1, 0));
    add2(6'b011000, 8'h98, 1,  o(8'h01, 0, 0, 0, 0), o(8'h99, 0, 0, 1, 0));
    add(6'b001100, 8'h98, 1,   o(8'h00, 0, 0, 0, 0));
    #2 reset_n = 0;
    repeat (2) @(negedge clk);
    chk("reset_w1", {d1, r1, h1, e1, t1}, 12'h000);
    chk("reset_w0", {d0, r0, h0, e0, t0}, 12'h000);
    reset_n = 1;
    foreach (vt[i]) begin
      {start, stop, up, clear, load, lap} = vt[i].ctl;
      preset = vt[i].preset;
      for (int w = 0; w < vt[i].ncyc; w++) begin
        @(negedge clk);
        if (w == 0) {start, stop, clear, load, lap} = 5'b0;
      end
      chk($sformatf("vec%0d_w1", i), {d1, r1, h1, e1, t1}, vt[i].exp1);
      chk($sformatf("vec%0d_w0", i), {d0, r0, h0, e0, t0}, vt[i].exp0);
    end
    up = 1; preset = 8'h40; load = 1;
    @(negedge clk); load = 0; start = 1;
    @(negedge clk); start = 0; lap = 1;
    @(negedge clk); lap = 0;
    repeat (13) @(negedge clk);
    chk("pre_async_run_hold", {8'h00, r1, h1, r0, h0}, 12'h00F);
    @(posedge clk); #3 reset_n = 0; #1;
    chk("async_w1", {d1, r1, h1, e1, t1}, 12'h000);
    chk("async_w0", {d0, r0, h0, e0, t0}, 12'h000);
    @(negedge clk); reset_n = 1;
    @(negedge clk);
    chk("post_rst_idle", {d1, r1, h1, e1, t1}, 12'h000);
    start = 1;
    @(negedge clk); start = 0;
    repeat (10) @(negedge clk);
    chk("post_rst_tick_w1", {d1, r1, h1, e1, t1}, o(8'h01, 1, 0, 0, 1));
    chk("post_rst_tick_w0", {d0, r0, h0, e0, t0}, o(8'h01, 1, 0, 0, 1));
    @(negedge clk); reset_n = 0; {start, stop, clear, load, lap} = 5'b0; up = 1;
    @(negedge clk); reset_n = 1;
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      chk("rnd_w1", {d1, r1, h1, e1, t1}, exp_of(0));
      chk("rnd_w0", {d0, r0, h0, e0, t0}, exp_of(1));
      start = $urandom_range(0, 7) == 0;
      stop = $urandom_range(0, 39) == 0;
      if ($urandom_range(0, 31) == 0) up = !up;
      clear = $urandom_range(0, 59) == 0;
      load = $urandom_range(0, 19) == 0;
      if ($urandom_range(0, 3) == 0) lap = !lap;
      p = $urandom_range(0, 5);
      preset = (p == 0) ? 8'h00 : (p == 1) ? 8'h01 : (p == 2) ? 8'h98 : (p == 3) ? 8'h99 : 8'($urandom);
      model_step(0, 1);
      model_step(1, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
